// File: rtl/subpel_interp_2d.sv
// Separable HEVC 8-tap luma interpolator for a BLK_W x BLK_H block at any quarter-pel
// position; one padded reference row in and one interpolated row out per beat.
module subpel_interp_2d #(
    parameter int BLK_W     = 8,
    parameter int BLK_H     = 8,
    parameter int BIT_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [1:0]                     frac_x,
    input  logic [1:0]                     frac_y,
    output logic                           busy,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [(BLK_W+7)*BIT_DEPTH-1:0] in_row,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [BLK_W*BIT_DEPTH-1:0]     out_row,
    output logic                           out_last,
    output logic                           done
);
    localparam int ROWS = BLK_H + 7;
    localparam int RW   = $clog2(ROWS + 1);
    localparam int MAXV = (1 << BIT_DEPTH) - 1;
    localparam int RND  = 1 << (13 - BIT_DEPTH);

    // Coefficient k occupies byte k.
    localparam logic [63:0] TAPS_A = {8'sd0, 8'sd1, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1};
    localparam logic [63:0] TAPS_B = {-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1};
    localparam logic [63:0] TAPS_C = {-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state, state_nx;
    logic [1:0]         fx, fy;
    logic [RW-1:0]      in_cnt;
    logic               en, accept, fire, last_hs;
    logic signed [15:0] h_nx [BLK_W];
    logic signed [15:0] s1_h [BLK_W];
    logic               s1_valid;
    logic [RW-1:0]      s1_row;
    logic signed [15:0] win  [8][BLK_W];
    logic signed [15:0] nwin [8][BLK_W];
    logic [RW-1:0]      out_idx;
    logic signed [20:0] hacc;
    logic signed [23:0] vacc, p, q;
    logic [BLK_W*BIT_DEPTH-1:0] o_nx;

    function automatic logic signed [7:0] coef(input logic [1:0] f, input logic [2:0] k);
        logic [63:0] t;
        unique case (f)
            2'd1:    t = TAPS_A;
            2'd2:    t = TAPS_B;
            default: t = TAPS_C;
        endcase
        return $signed(t[{k, 3'b000} +: 8]);
    endfunction

    assign en       = !out_valid || out_ready;
    assign in_ready = en && (state == RUN);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign out_last = out_valid && (out_idx == RW'(BLK_H - 1));
    assign last_hs  = out_valid && out_ready && out_last;
    assign fire     = s1_valid && (s1_row >= RW'(7));

    always_comb begin
        h_nx = '{default: '0};
        hacc = '0;
        for (int unsigned i = 0; i < BLK_W; i++) begin
            hacc = '0;
            for (int unsigned k = 0; k < 8; k++)
                hacc = hacc + 21'(coef(fx, 3'(k)))
                            * 21'($signed({1'b0, in_row[(i+k)*BIT_DEPTH +: BIT_DEPTH]}));
            if (fx == 2'd0)
                h_nx[i] = 16'(in_row[(i+3)*BIT_DEPTH +: BIT_DEPTH]) << (14 - BIT_DEPTH);
            else
                h_nx[i] = 16'(hacc >>> (BIT_DEPTH - 8));
        end
    end

    // The vertical filter reads the window as it will look after the incoming row
    // shifts in, so output row r is registered on the same edge that row r+7 enters.
    for (genvar k = 0; k < 8; k++) begin : g_nwin
        if (k < 7) begin : g_old
            assign nwin[k] = win[k+1];
        end else begin : g_new
            assign nwin[k] = s1_h;
        end
    end

    always_comb begin
        vacc = '0;
        p    = '0;
        q    = '0;
        o_nx = '0;
        for (int unsigned i = 0; i < BLK_W; i++) begin
            vacc = '0;
            for (int unsigned k = 0; k < 8; k++)
                vacc = vacc + 24'(coef(fy, 3'(k))) * 24'(nwin[k][i]);
            p = (fy == 2'd0) ? 24'(nwin[3][i]) : (vacc >>> 6);
            q = (p + 24'(RND)) >>> (14 - BIT_DEPTH);
            if (q < 0)
                o_nx[i*BIT_DEPTH +: BIT_DEPTH] = '0;
            else if (q > 24'(MAXV))
                o_nx[i*BIT_DEPTH +: BIT_DEPTH] = '1;
            else
                o_nx[i*BIT_DEPTH +: BIT_DEPTH] = q[BIT_DEPTH-1:0];
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (accept && in_cnt == RW'(ROWS - 1)) state_nx = DRAIN;
            DRAIN:   if (last_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fx        <= '0;
            fy        <= '0;
            in_cnt    <= '0;
            s1_valid  <= 1'b0;
            s1_row    <= '0;
            s1_h      <= '{default: '0};
            win       <= '{default: '0};
            out_valid <= 1'b0;
            out_row   <= '0;
            out_idx   <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == DRAIN) && last_hs;
            if (state == IDLE && start) begin
                fx     <= frac_x;
                fy     <= frac_y;
                in_cnt <= '0;
            end else if (accept) begin
                in_cnt <= in_cnt + RW'(1);
            end
            if (en) begin
                s1_valid  <= accept;
                out_valid <= fire;
                if (accept) begin
                    s1_h   <= h_nx;
                    s1_row <= in_cnt;
                end
                if (s1_valid)
                    win <= nwin;
                if (fire) begin
                    out_row <= o_nx;
                    out_idx <= s1_row - RW'(7);
                end
            end
        end
    end
endmodule

// File: tb/tb_subpel_interp_2d.sv
// Bench for subpel_interp_2d: a reference model fills an expected-row queue as input
// rows are accepted; rows leaving the DUT are compared against it.
`timescale 1ns/1ps
module tb_subpel_interp_2d;
    localparam int ROWS = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, busy, in_valid, in_ready, out_valid, out_ready, out_last, done;
    logic [1:0]   frac_x, frac_y;
    logic [119:0] in_row;
    logic [63:0]  out_row;

    logic         start10, busy10, in_valid10, in_ready10, out_valid10, out_ready10, out_last10, done10;
    logic [1:0]   frac_x10, frac_y10;
    logic [149:0] in_row10;
    logic [79:0]  out_row10;

    subpel_interp_2d #(.BLK_W(8), .BLK_H(8), .BIT_DEPTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .frac_x(frac_x), .frac_y(frac_y), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_last(out_last), .done(done));

    subpel_interp_2d #(.BLK_W(8), .BLK_H(8), .BIT_DEPTH(10)) u_dut10 (
        .clk(clk), .rst(rst), .start(start10), .frac_x(frac_x10), .frac_y(frac_y10), .busy(busy10),
        .in_valid(in_valid10), .in_ready(in_ready10), .in_row(in_row10),
        .out_valid(out_valid10), .out_ready(out_ready10), .out_row(out_row10),
        .out_last(out_last10), .done(done10));

    int checks = 0;
    int errors = 0;
    logic [119:0] rows [ROWS];
    logic [63:0]  exp_q[$];
    logic [63:0]  got_q[$];
    bit           last_q[$];
    bit           timeout, busy_at_done;
    int           done_lat, lat, stall_viol;

    function automatic int tapv(input int f, input int t);
        int a [8] = '{-1, 4, -10, 58, 17, -5, 1, 0};
        int b [8] = '{-1, 4, -11, 40, 40, -11, 4, -1};
        int c [8] = '{0, 1, -5, 17, 58, -10, 4, -1};
        case (f)
            1:       return a[t];
            2:       return b[t];
            default: return c[t];
        endcase
    endfunction

    function automatic int smp(input int y, input int j);
        logic [119:0] r;
        r = rows[y];
        return int'(r[j*8 +: 8]);
    endfunction

    // 8-bit reference: output row r from input rows r..r+7.
    function automatic logic [63:0] model_row(input int r, input int fx, input int fy);
        int hv [8][8];
        int acc, p, q;
        logic [63:0] res;
        res = '0;
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < 8; i++) begin
                if (fx == 0) hv[k][i] = smp(r + k, i + 3) * 64;
                else begin
                    acc = 0;
                    for (int t = 0; t < 8; t++) acc += tapv(fx, t) * smp(r + k, i + t);
                    hv[k][i] = acc;
                end
            end
        for (int i = 0; i < 8; i++) begin
            if (fy == 0) p = hv[3][i];
            else begin
                acc = 0;
                for (int t = 0; t < 8; t++) acc += tapv(fy, t) * hv[t][i];
                p = acc >>> 6;
            end
            q = (p + 32) >>> 6;
            if (q < 0) q = 0;
            else if (q > 255) q = 255;
            res[i*8 +: 8] = 8'(q);
        end
        return res;
    endfunction

    task automatic fill_random();
        for (int y = 0; y < ROWS; y++)
            for (int j = 0; j < 15; j++) rows[y][j*8 +: 8] = 8'($urandom_range(0, 255));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        start10 = 1'b0; in_valid10 = 1'b0; out_ready10 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic stream_block(input logic [1:0] fx, input logic [1:0] fy, input bit do_start,
                                input bit stall, input bit poke, input bit chain,
                                input logic [1:0] nfx, input logic [1:0] nfy);
        int row, last_cyc, acc7, first_v;
        logic [63:0] prev_row;
        bit prev_stall;
        row = 0; last_cyc = -1; acc7 = -1; first_v = -1; prev_row = '0; prev_stall = 0;
        timeout = 1; done_lat = -1; lat = -1; stall_viol = 0; busy_at_done = 1;
        exp_q.delete(); got_q.delete(); last_q.delete();
        if (do_start) begin
            @(negedge clk);
            start = 1'b1; frac_x = fx; frac_y = fy;
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke && cyc == 4) begin
                start = 1'b1; frac_x = ~fx; frac_y = ~fy;
            end
            in_valid = (row < ROWS);
            if (row < ROWS) in_row = rows[row];
            out_ready = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            #1;
            if (prev_stall && out_row !== prev_row) stall_viol++;
            if (out_valid && !out_ready && in_ready) stall_viol++;
            if (first_v < 0 && out_valid) first_v = cyc;
            if (in_valid && in_ready) begin
                if (row == 7) acc7 = cyc;
                if (row >= 7) exp_q.push_back(model_row(row - 7, fx, fy));
                row++;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_row);
                last_q.push_back(out_last);
                if (out_last) last_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_row = out_row;
            if (done) begin
                done_lat = (last_cyc >= 0) ? cyc - last_cyc : -1;
                busy_at_done = busy;
                timeout = 0;
                if (chain) begin
                    start = 1'b1; frac_x = nfx; frac_y = nfy;
                end
                break;
            end
        end
        in_valid = 1'b0;
        lat = (acc7 >= 0 && first_v >= 0) ? first_v - acc7 : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; frac_x = '0; frac_y = '0;
        in_row = '0; start10 = 1'b0; in_valid10 = 1'b0; out_ready10 = 1'b0;
        frac_x10 = '0; frac_y10 = '0; in_row10 = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, in_ready, out_valid, out_last, done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {busy, in_ready, out_valid, out_last, done});
        end
        checks++;
        if (out_row !== 64'd0) begin
            errors++; $display("FAIL reset_row: got %h want 0", out_row);
        end
        checks++;
        if ({busy10, out_valid10, done10} !== 3'b0 || out_row10 !== 80'd0) begin
            errors++; $display("FAIL reset_10b: got %b/%h want 000/0", {busy10, out_valid10, done10}, out_row10);
        end
        rst = 1'b0;
    endtask

    task automatic test_integer_copy();
        logic [63:0] g, e, f;
        bit [7:0] lastv;
        int n;
        for (int y = 0; y < ROWS; y++)
            for (int j = 0; j < 15; j++) rows[y][j*8 +: 8] = 8'((y * 16 + j) & 255);
        do_reset();
        stream_block(2'd0, 2'd0, 1, 0, 0, 0, 2'd0, 2'd0);
        checks++;
        if (timeout || got_q.size() != 8) begin
            errors++; $display("FAIL int_count: got %0d rows timeout=%0d want 8 rows", got_q.size(), timeout);
        end
        lastv = '0;
        for (int r = 0; r < last_q.size() && r < 8; r++) lastv[r] = last_q[r];
        checks++;
        if (lastv !== 8'b1000_0000) begin
            errors++; $display("FAIL int_last: got %b want 10000000", lastv);
        end
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            for (int i = 0; i < 8; i++) f[i*8 +: 8] = 8'(((n + 3) * 16 + i + 3) & 255);
            checks++;
            if (g !== e || g !== f) begin
                errors++; $display("FAIL int_row%0d: got %h want %h", n, g, f);
            end
            n++;
        end
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL int_latency: got %0d want 2", lat);
        end
        checks++;
        if (done_lat !== 1 || busy_at_done !== 1'b0) begin
            errors++; $display("FAIL int_done: got lat %0d busy %0d want 1 0", done_lat, busy_at_done);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL int_done_pulse: got %0d want 0", done);
        end
    endtask

    task automatic test_h_impulse();
        logic [63:0] g, e;
        int n;
        for (int y = 0; y < ROWS; y++) rows[y] = '0;
        rows[3][3*8 +: 8] = 8'd64;
        do_reset();
        stream_block(2'd1, 2'd0, 1, 0, 0, 0, 2'd0, 2'd0);
        checks++;
        if (timeout || got_q.size() != 8) begin
            errors++; $display("FAIL himp_count: got %0d rows want 8", got_q.size());
        end
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (n == 0) e = 64'h0000_0000_0004_003A;
            checks++;
            if (g !== e) begin
                errors++; $display("FAIL himp_row%0d: got %h want %h", n, g, e);
            end
            n++;
        end
    endtask

    task automatic test_const_2d();
        logic [63:0] g, e;
        int n;
        for (int y = 0; y < ROWS; y++) rows[y] = '1;
        do_reset();
        stream_block(2'd2, 2'd2, 1, 0, 0, 0, 2'd0, 2'd0);
        checks++;
        if (timeout || got_q.size() != 8) begin
            errors++; $display("FAIL c8_count: got %0d rows want 8", got_q.size());
        end
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e || g !== 64'hFFFF_FFFF_FFFF_FFFF) begin
                errors++; $display("FAIL c8_row%0d: got %h want ffffffffffffffff", n, g);
            end
            n++;
        end
    endtask

    task automatic test_const_2d_10bit();
        logic [79:0] q10[$];
        logic [79:0] e;
        int row, n;
        bit fin;
        do_reset();
        @(negedge clk);
        start10 = 1'b1; frac_x10 = 2'd2; frac_y10 = 2'd2;
        row = 0; n = 0; fin = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            start10 = 1'b0;
            in_valid10 = (row < ROWS);
            in_row10 = '1;
            out_ready10 = 1'b1;
            #1;
            if (in_valid10 && in_ready10) begin
                if (row >= 7) q10.push_back({80{1'b1}});
                row++;
            end
            if (out_valid10 && out_ready10) begin
                checks++;
                if (q10.size() == 0) begin
                    errors++; $display("FAIL c10_extra: got row %h want none", out_row10);
                end else begin
                    e = q10.pop_front();
                    if (out_row10 !== e) begin
                        errors++; $display("FAIL c10_row%0d: got %h want %h", n, out_row10, e);
                    end
                end
                n++;
            end
            if (done10) begin
                fin = 1;
                break;
            end
        end
        in_valid10 = 1'b0;
        checks++;
        if (!fin || n != 8) begin
            errors++; $display("FAIL c10_count: got %0d rows done=%0d want 8 1", n, fin);
        end
    endtask

    task automatic test_back_pressure();
        logic [63:0] g, e;
        int n;
        fill_random();
        do_reset();
        stream_block(2'd3, 2'd1, 1, 1, 0, 0, 2'd0, 2'd0);
        checks++;
        if (timeout || got_q.size() != 8) begin
            errors++; $display("FAIL bp_count: got %0d rows want 8", got_q.size());
        end
        checks++;
        if (stall_viol != 0) begin
            errors++; $display("FAIL bp_stall: got %0d violations want 0", stall_viol);
        end
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++; $display("FAIL bp_row%0d: got %h want %h", n, g, e);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid_block();
        logic [63:0] g, e;
        int n;
        bit saw;
        fill_random();
        do_reset();
        @(negedge clk);
        start = 1'b1; frac_x = 2'd1; frac_y = 2'd2;
        n = 0;
        for (int cyc = 0; cyc < 20 && n < 5; cyc++) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b1; in_row = rows[n]; out_ready = 1'b1;
            #1;
            if (in_valid && in_ready) n++;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (n != 5 || {busy, out_valid, in_ready} !== 3'b000) begin
            errors++; $display("FAIL rst_mid: got acc %0d busy/ov/ir %b want 5 000", n, {busy, out_valid, in_ready});
        end
        rst = 1'b0;
        saw = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (done || out_valid) saw = 1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++; $display("FAIL rst_nodone: got activity %0d want 0", saw);
        end
        fill_random();
        stream_block(2'd2, 2'd3, 1, 0, 0, 0, 2'd0, 2'd0);
        checks++;
        if (timeout || got_q.size() != 8) begin
            errors++; $display("FAIL rst_count: got %0d rows want 8", got_q.size());
        end
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++; $display("FAIL rst_row%0d: got %h want %h", n, g, e);
            end
            n++;
        end
    endtask

    task automatic test_start_ignored();
        logic [63:0] g, e;
        int n;
        fill_random();
        do_reset();
        stream_block(2'd1, 2'd3, 1, 0, 1, 0, 2'd0, 2'd0);
        checks++;
        if (timeout || got_q.size() != 8) begin
            errors++; $display("FAIL ign_count: got %0d rows want 8", got_q.size());
        end
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++; $display("FAIL ign_row%0d: got %h want %h", n, g, e);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] g, e;
        int n;
        fill_random();
        do_reset();
        stream_block(2'd2, 2'd1, 1, 0, 0, 1, 2'd3, 2'd2);
        checks++;
        if (timeout || got_q.size() != 8 || done_lat !== 1) begin
            errors++; $display("FAIL b2b_first: got %0d rows done lat %0d want 8 1", got_q.size(), done_lat);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++; $display("FAIL b2b_a: got %h want %h", g, e);
            end
        end
        fill_random();
        stream_block(2'd3, 2'd2, 0, 0, 0, 0, 2'd0, 2'd0);
        checks++;
        if (timeout || got_q.size() != 8) begin
            errors++; $display("FAIL b2b_second: got %0d rows want 8", got_q.size());
        end
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++; $display("FAIL b2b_row%0d: got %h want %h", n, g, e);
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_integer_copy();
        test_h_impulse();
        test_const_2d();
        test_const_2d_10bit();
        test_back_pressure();
        test_reset_mid_block();
        test_start_ignored();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
